// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared composite-video level constants and types
// Levels are 6-bit unsigned: 0 = sync tip, 12 = pedestal, 63 = peak white.
package video_pkg;

    localparam int C_W_VIDEO  = 6;
    localparam int C_LVL_SYNC = 0;
    localparam int C_LVL_PEDE = 12;
    localparam int C_LVL_MAX  = 63;

    typedef logic [5:0] video_lvl_t;

endpackage

// File: rtl/video_dsm_lfsr.sv
// rtl/video_dsm_lfsr.sv - 15-bit Fibonacci LFSR (x^15 + x^14 + 1) used as dither source
// Ports:
//   CK_i    in   clock
//   ARST_i  in   asynchronous reset, active high; loads C_SEED
//   EN_i    in   1 = advance one step this cycle
//   LFSR_o  out  current register state (period 32767 for any non-zero seed)
module video_dsm_lfsr #(
    parameter logic [14:0] C_SEED = 15'h0001
) (
    input  logic        CK_i,
    input  logic        ARST_i,
    input  logic        EN_i,
    output logic [14:0] LFSR_o
);

    always_ff @(posedge CK_i or posedge ARST_i) begin
        if (ARST_i) begin
            LFSR_o <= C_SEED;
        end else if (EN_i) begin
            LFSR_o <= {LFSR_o[13:0], LFSR_o[14] ^ LFSR_o[13]};
        end
    end

endmodule

// File: rtl/video_dsm_dac.sv
// rtl/video_dsm_dac.sv - 1-bit delta-sigma DAC for the composite-video level
// Optional dither: define VIDEO_DSM_DITHER_EN to add LFSR dither at the order-2 quantiser.
// Ports:
//   CK_i      in   modulator clock
//   ARST_i    in   asynchronous reset, active high
//   CK_EE_i   in   sample strobe (single-cycle pulse, or held 1 to sample every cycle)
//   VIDEOs_i  in   unsigned video level, C_W_IN bits
//   MUTE_i    in   1 = the sample captured on this strobe is forced to 0
//   DAC_o     out  registered bitstream, inverted when C_XOUT = 1
//   OVF_o     out  sticky flag: order-2 second integrator saturated since reset
import video_pkg::*;

module video_dsm_dac #(
    parameter int   C_W_IN  = C_W_VIDEO,
    parameter int   C_ORDER = 2,
    parameter logic C_XOUT  = 1'b0
) (
    input  logic              CK_i,
    input  logic              ARST_i,
    input  logic              CK_EE_i,
    input  logic [C_W_IN-1:0] VIDEOs_i,
    input  logic              MUTE_i,
    output logic              DAC_o,
    output logic              OVF_o
);

    logic [C_W_IN-1:0] x;
    logic              y;

    // Captured sample; the modulator sees it one cycle later.
    always_ff @(posedge CK_i or posedge ARST_i) begin
        if (ARST_i) begin
            x <= '0;
        end else if (CK_EE_i) begin
            x <= MUTE_i ? '0 : VIDEOs_i;
        end
    end

`ifdef VIDEO_DSM_DITHER_EN
    logic [14:0] lfsr;

    video_dsm_lfsr #(
        .C_SEED (15'h0001)
    ) u_lfsr (
        .CK_i   (CK_i),
        .ARST_i (ARST_i),
        .EN_i   (1'b1),
        .LFSR_o (lfsr)
    );
`endif

    generate
        if (C_ORDER == 1) begin : g_order1
            // First-order: the carry out of a wrapping accumulator is the bitstream.
            logic [C_W_IN-1:0] acc;
            logic [C_W_IN:0]   s;

            assign s     = {1'b0, acc} + {1'b0, x};
            assign y     = s[C_W_IN];
            assign OVF_o = 1'b0;

            always_ff @(posedge CK_i or posedge ARST_i) begin
                if (ARST_i) begin
                    acc <= '0;
                end else begin
                    acc <= s[C_W_IN-1:0];
                end
            end
        end else if (C_ORDER == 2) begin : g_order2
            // Second-order CIFB. Intermediates carry one guard bit over the
            // integrator registers so the saturation test cannot wrap.
            localparam int C_WI = C_W_IN + 4;
            localparam logic signed [C_WI:0] C_FS   = (C_WI+1)'(2**C_W_IN);
            localparam logic signed [C_WI:0] C_SAT  = (C_WI+1)'(2**(C_W_IN+2));
            localparam logic signed [C_WI:0] C_ZERO = '0;

            logic signed [C_WI-1:0] i1;
            logic signed [C_WI-1:0] i2;
            logic signed [C_WI:0]   fb;
            logic signed [C_WI:0]   xe;
            logic signed [C_WI:0]   d;
            logic signed [C_WI:0]   i1n;
            logic signed [C_WI:0]   i2r;
            logic signed [C_WI:0]   i2n;
            logic signed [C_WI:0]   q;
            logic                   sat;
            logic                   y_prev;

            assign fb = y_prev ? C_FS : '0;
            assign xe = {{(C_WI+1-C_W_IN){1'b0}}, x};

`ifdef VIDEO_DSM_DITHER_EN
            // Two LSBs of the LFSR read as a signed value: -2..+1.
            assign d = {{(C_WI-1){lfsr[1]}}, lfsr[1:0]};
`else
            assign d = '0;
`endif

            always_comb begin
                i1n = {i1[C_WI-1], i1} + xe - fb;
                i2r = {i2[C_WI-1], i2} + i1n - fb;
                i2n = i2r;
                sat = 1'b0;
                if (i2r > C_SAT) begin
                    i2n = C_SAT;
                    sat = 1'b1;
                end else if (i2r < -C_SAT) begin
                    i2n = -C_SAT;
                    sat = 1'b1;
                end
            end

            assign q = i2n + d;
            assign y = (q >= C_ZERO);

            always_ff @(posedge CK_i or posedge ARST_i) begin
                if (ARST_i) begin
                    i1     <= '0;
                    i2     <= '0;
                    y_prev <= 1'b0;
                    OVF_o  <= 1'b0;
                end else begin
                    i1     <= i1n[C_WI-1:0];
                    i2     <= i2n[C_WI-1:0];
                    y_prev <= y;
                    OVF_o  <= OVF_o | sat;
                end
            end
        end else begin : g_bad_order
            $error("video_dsm_dac: C_ORDER must be 1 or 2");
            assign y     = 1'b0;
            assign OVF_o = 1'b0;
        end
    endgenerate

    // Polarity is applied here so the modulator state is independent of C_XOUT.
    always_ff @(posedge CK_i or posedge ARST_i) begin
        if (ARST_i) begin
            DAC_o <= C_XOUT;
        end else begin
            DAC_o <= y ^ C_XOUT;
        end
    end

endmodule
